// File: rtl/lcd_host_if.sv
// Bus bundle between the LCD host block and its surroundings: image preload,
// command FIFO, LCD controller handshake, image ROM read port and result
// capture stream, plus a debug view of the issue FSM state.
//
// Handshake: cmd_valid is a single-cycle strobe with no ready; the controller
// signals readiness through busy=0 before each issue, and a cmd_valid pulse is
// always followed by at least one cycle with cmd_valid=0.
interface lcd_host_if;
    logic       img_wr;
    logic [5:0] img_addr;
    logic [7:0] img_data;
    logic       cmd_push;
    logic [3:0] cmd_in;
    logic       start;
    logic       cmd_full;
    logic       cmd_empty;
    logic       cmd_ovf;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic [6:0] ram_cnt;
    logic [15:0] checksum;
    logic       seq_err;
    logic       finish;
    logic [2:0] dbg_state;

    modport master (
        output img_wr, img_addr, img_data, cmd_push, cmd_in, start,
               busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D,
        input  cmd_full, cmd_empty, cmd_ovf, cmd, cmd_valid, IROM_Q,
               ram_cnt, checksum, seq_err, finish, dbg_state
    );

    modport slave (
        input  img_wr, img_addr, img_data, cmd_push, cmd_in, start,
               busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D,
        output cmd_full, cmd_empty, cmd_ovf, cmd, cmd_valid, IROM_Q,
               ram_cnt, checksum, seq_err, finish, dbg_state
    );
endinterface

// File: rtl/lcd_host.sv
// LCD host: holds a 64x8 image store served as a one-cycle-latency ROM,
// queues command codes in a FIFO, issues them to the LCD controller one at a
// time, and captures the controller's write-out stream (count, sum, order).
module lcd_host #(
    parameter int CMD_DEPTH = 16
) (
    input logic        clk,
    input logic        reset,
    lcd_host_if.slave  bus
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_DEPTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ISSUE    = 3'd2,
        HOLD     = 3'd3,
        COLLECT  = 3'd4,
        FIN      = 3'd5
    } state_t;

    state_t      state;
    logic [7:0]  store [64];
    logic [3:0]  fifo_mem [CMD_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push_ok;
    logic        beat;
    logic [5:0]  exp_addr;
    logic        ovf;
    logic [3:0]  cmd_r;
    logic        cmd_valid_r;
    logic        finish_r;
    logic [7:0]  irom_q_r;
    logic [6:0]  ram_cnt_r;
    logic [15:0] checksum_r;
    logic        seq_err_r;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // The head was latched into cmd when entering ISSUE, so popping there
    // frees the slot a simultaneous push on a full FIFO may overwrite.
    assign pop     = (state == ISSUE) && !empty;
    assign push_ok = bus.cmd_push && (!full || pop);
    assign beat    = (state == COLLECT) && bus.IRAM_valid;

    assign bus.cmd_full  = full;
    assign bus.cmd_empty = empty;
    assign bus.cmd_ovf   = ovf;
    assign bus.cmd       = cmd_r;
    assign bus.cmd_valid = cmd_valid_r;
    assign bus.IROM_Q    = irom_q_r;
    assign bus.ram_cnt   = ram_cnt_r;
    assign bus.checksum  = checksum_r;
    assign bus.seq_err   = seq_err_r;
    assign bus.finish    = finish_r;
    assign bus.dbg_state = state;

    // Image store writes (blocked during ISSUE) and registered ROM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) store[i] <= 8'd0;
            irom_q_r <= 8'd0;
        end else begin
            if (bus.img_wr && state != ISSUE) store[bus.img_addr] <= bus.img_data;
            if (bus.IROM_rd) irom_q_r <= store[bus.IROM_A];
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.cmd_in;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (bus.cmd_push && full && !pop) ovf <= 1'b1;
        end
    end

    // Issue FSM with registered cmd, cmd_valid and finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd_r       <= 4'd0;
            cmd_valid_r <= 1'b0;
            finish_r    <= 1'b0;
        end else begin
            cmd_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) state <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (!bus.busy && !empty) begin
                        state       <= ISSUE;
                        cmd_valid_r <= 1'b1;
                        cmd_r       <= fifo_mem[rd_ptr];
                    end
                end
                ISSUE: begin
                    // Code 0 is write-out: collect results, issue nothing more.
                    state <= (cmd_r == 4'd0) ? COLLECT : HOLD;
                end
                HOLD: begin
                    state <= WAIT_RDY;
                end
                COLLECT: begin
                    if (bus.done) begin
                        state    <= FIN;
                        finish_r <= 1'b1;
                    end
                end
                FIN: begin
                    state <= FIN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result capture: count, byte sum and address-order check in COLLECT.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_cnt_r  <= 7'd0;
            checksum_r <= 16'd0;
            seq_err_r  <= 1'b0;
            exp_addr   <= 6'd0;
        end else if (beat) begin
            if (ram_cnt_r != 7'd64) ram_cnt_r <= ram_cnt_r + 7'd1;
            checksum_r <= checksum_r + {8'd0, bus.IRAM_D};
            exp_addr   <= exp_addr + 6'd1;
            if (bus.IRAM_A != exp_addr) seq_err_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_host.sv
// Bench for lcd_host: ROM read vectors, command issue scoreboard, FIFO
// full/overflow corners, capture stream and reset abort sequences.
module tb_lcd_host;
    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_COLLECT = 3'd4, S_FIN = 3'd5;

    typedef struct {
        logic       rd;
        logic [5:0] addr;
        logic [7:0] exp_q;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] exp_q[$];
    logic prev_valid = 1'b0;
    logic [15:0] exp_sum;
    vec_t vecs[6];

    always #5 clk = ~clk;

    lcd_host_if bus();

    lcd_host #(.CMD_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge, then pulses scored.
    task automatic tick();
        logic [3:0] e;
        @(posedge clk);
        @(negedge clk);
        if (bus.cmd_valid) begin
            check("cmd_gap", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cmd_unexpected actual=%0h required=no_pulse", bus.cmd);
            end else begin
                e = exp_q.pop_front();
                check("cmd_code", {28'd0, bus.cmd}, {28'd0, e});
            end
        end
        prev_valid = bus.cmd_valid;
    endtask

    task automatic clear_inputs();
        bus.img_wr = 0; bus.img_addr = 0; bus.img_data = 0;
        bus.cmd_push = 0; bus.cmd_in = 0; bus.start = 0;
        bus.busy = 0; bus.done = 0; bus.IROM_rd = 0; bus.IROM_A = 0;
        bus.IRAM_valid = 0; bus.IRAM_A = 0; bus.IRAM_D = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_sum = 16'd0;
    endtask

    task automatic check_reset();
        check("rst_state", {29'd0, bus.dbg_state}, {29'd0, S_IDLE});
        check("rst_empty", {31'd0, bus.cmd_empty}, 32'd1);
        check("rst_full", {31'd0, bus.cmd_full}, 32'd0);
        check("rst_ovf", {31'd0, bus.cmd_ovf}, 32'd0);
        check("rst_cmd", {28'd0, bus.cmd}, 32'd0);
        check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("rst_irom_q", {24'd0, bus.IROM_Q}, 32'd0);
        check("rst_ram_cnt", {25'd0, bus.ram_cnt}, 32'd0);
        check("rst_checksum", {16'd0, bus.checksum}, 32'd0);
        check("rst_seq_err", {31'd0, bus.seq_err}, 32'd0);
        check("rst_finish", {31'd0, bus.finish}, 32'd0);
    endtask

    task automatic push(input logic [3:0] code, input bit track);
        bus.cmd_push = 1'b1;
        bus.cmd_in = code;
        tick();
        bus.cmd_push = 1'b0;
        if (track) exp_q.push_back(code);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        int n = 0;
        while (bus.dbg_state !== target && n < budget) begin
            tick();
            n++;
        end
        check("wait_state", {29'd0, bus.dbg_state}, {29'd0, target});
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (bus.cmd_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid", {31'd0, bus.cmd_valid}, 32'd1);
    endtask

    task automatic beat(input logic [5:0] a, input logic [7:0] d);
        bus.IRAM_valid = 1'b1;
        bus.IRAM_A = a;
        bus.IRAM_D = d;
        tick();
        bus.IRAM_valid = 1'b0;
        exp_sum = exp_sum + {8'd0, d};
    endtask

    task automatic preload();
        for (int k = 0; k < 64; k++) begin
            bus.img_wr = 1'b1;
            bus.img_addr = 6'(k);
            bus.img_data = 8'(k);
            tick();
        end
        bus.img_wr = 1'b0;
    endtask

    initial begin
        logic any_v;
        logic [3:0] code;
        int n;

        vecs[0] = '{1'b1, 6'd9,  8'hA5};
        vecs[1] = '{1'b0, 6'd20, 8'hA5};
        vecs[2] = '{1'b1, 6'd63, 8'd63};
        vecs[3] = '{1'b0, 6'd1,  8'd63};
        vecs[4] = '{1'b1, 6'd0,  8'd0};
        vecs[5] = '{1'b1, 6'd42, 8'd42};

        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        do_reset();
        check_reset();

        // Store is cleared by reset.
        preload();
        do_reset();
        bus.IROM_rd = 1'b1; bus.IROM_A = 6'd7;
        tick();
        check("store_cleared", {24'd0, bus.IROM_Q}, 32'd0);
        bus.IROM_rd = 1'b0;

        // Full ROM sweep: Q follows previous cycle's address.
        preload();
        bus.IROM_rd = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.IROM_A = 6'(i);
            tick();
            check("irom_sweep", {24'd0, bus.IROM_Q}, i);
        end
        bus.IROM_rd = 1'b0;

        // Vector table, including hold when IROM_rd=0.
        bus.img_wr = 1'b1; bus.img_addr = 6'd9; bus.img_data = 8'hA5;
        tick();
        bus.img_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.IROM_rd = vecs[i].rd;
            bus.IROM_A = vecs[i].addr;
            tick();
            check("irom_vec", {24'd0, bus.IROM_Q}, {24'd0, vecs[i].exp_q});
        end
        bus.IROM_rd = 1'b0;

        // Beats outside COLLECT are ignored.
        beat(6'd3, 8'd9);
        exp_sum = 16'd0;
        check("idle_beat_cnt", {25'd0, bus.ram_cnt}, 32'd0);
        check("idle_beat_sum", {16'd0, bus.checksum}, 32'd0);
        check("idle_beat_err", {31'd0, bus.seq_err}, 32'd0);

        // Issue 1,4,5,0; trailing 6 must stay in the FIFO.
        push(4'd1, 1); push(4'd4, 1); push(4'd5, 1); push(4'd0, 1); push(4'd6, 0);
        pulse_start();
        wait_state(S_COLLECT, 60);
        check("issue_drained", exp_q.size(), 32'd0);
        check("leftover_kept", {31'd0, bus.cmd_empty}, 32'd0);
        check("cmd_hold", {28'd0, bus.cmd}, 32'd0);

        // Full 64-beat image.
        for (int i = 0; i < 64; i++) beat(6'(i), 8'(i));
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("img_cnt", {25'd0, bus.ram_cnt}, 32'd64);
        check("img_sum", {16'd0, bus.checksum}, 32'd2016);
        check("img_sum_model", {16'd0, bus.checksum}, {16'd0, exp_sum});
        check("img_err", {31'd0, bus.seq_err}, 32'd0);
        check("img_finish", {31'd0, bus.finish}, 32'd1);
        check("img_state", {29'd0, bus.dbg_state}, {29'd0, S_FIN});

        // FIN: beats ignored, pushes accepted, nothing issued, start ignored.
        beat(6'd7, 8'hFF);
        check("fin_beat_sum", {16'd0, bus.checksum}, 32'd2016);
        push(4'd3, 0);
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("fin_stay", {29'd0, bus.dbg_state}, {29'd0, S_FIN});
        check("fin_finish", {31'd0, bus.finish}, 32'd1);

        // busy holds off issue; first pulse right after busy drops.
        do_reset();
        clear_inputs();
        push(4'd2, 1); push(4'd3, 1);
        bus.busy = 1'b1;
        pulse_start();
        any_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_v = any_v | bus.cmd_valid;
        end
        check("busy_block", {31'd0, any_v}, 32'd0);
        bus.busy = 1'b0;
        tick();
        check("first_after_busy", {31'd0, bus.cmd_valid}, 32'd1);
        for (int i = 0; i < 12; i++) tick();
        check("busy_drained", exp_q.size(), 32'd0);
        check("busy_end_state", {29'd0, bus.dbg_state}, {29'd0, S_WAIT});

        // Fill to 16, push+pop on full, then overflow, then drain.
        do_reset();
        clear_inputs();
        bus.busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            code = 4'($urandom_range(1, 15));
            push(code, 1);
        end
        check("fill_full", {31'd0, bus.cmd_full}, 32'd1);
        check("fill_ovf", {31'd0, bus.cmd_ovf}, 32'd0);
        bus.busy = 1'b0;
        pulse_start();
        wait_valid(10);
        code = 4'($urandom_range(1, 15));
        bus.busy = 1'b1;
        push(code, 1);
        check("pushpop_full", {31'd0, bus.cmd_full}, 32'd1);
        check("pushpop_ovf", {31'd0, bus.cmd_ovf}, 32'd0);
        push(4'd0, 0);
        check("ovf_set", {31'd0, bus.cmd_ovf}, 32'd1);
        check("ovf_full", {31'd0, bus.cmd_full}, 32'd1);
        bus.busy = 1'b0;
        n = 0;
        while (!(bus.cmd_empty === 1'b1 && bus.dbg_state === S_WAIT) && n < 120) begin
            tick();
            n++;
        end
        check("ovf_drained", exp_q.size(), 32'd0);
        check("ovf_empty", {31'd0, bus.cmd_empty}, 32'd1);
        check("ovf_sticky", {31'd0, bus.cmd_ovf}, 32'd1);

        // Beat in the same cycle as done is still captured.
        do_reset();
        clear_inputs();
        push(4'd0, 1);
        pulse_start();
        wait_state(S_COLLECT, 20);
        beat(6'd0, 8'd10);
        beat(6'd1, 8'd20);
        bus.done = 1'b1;
        beat(6'd2, 8'd30);
        bus.done = 1'b0;
        check("done_beat_cnt", {25'd0, bus.ram_cnt}, 32'd3);
        check("done_beat_sum", {16'd0, bus.checksum}, {16'd0, exp_sum});
        check("done_beat_fin", {31'd0, bus.finish}, 32'd1);
        check("done_beat_err", {31'd0, bus.seq_err}, 32'd0);

        // Address skip sets seq_err; reset mid-stream clears everything.
        do_reset();
        clear_inputs();
        push(4'd0, 1);
        pulse_start();
        wait_state(S_COLLECT, 20);
        beat(6'd0, 8'($urandom_range(0, 255)));
        beat(6'd1, 8'($urandom_range(0, 255)));
        check("seq_ok", {31'd0, bus.seq_err}, 32'd0);
        beat(6'd3, 8'($urandom_range(0, 255)));
        check("seq_err", {31'd0, bus.seq_err}, 32'd1);
        check("seq_cnt", {25'd0, bus.ram_cnt}, 32'd3);
        check("seq_sum", {16'd0, bus.checksum}, {16'd0, exp_sum});
        bus.IRAM_valid = 1'b1; bus.IRAM_A = 6'd4; bus.IRAM_D = 8'd77;
        do_reset();
        clear_inputs();
        check_reset();

        // Reset during ISSUE leaves no residual pulse.
        push(4'd5, 1);
        pulse_start();
        wait_valid(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("abort_state", {29'd0, bus.dbg_state}, {29'd0, S_IDLE});
        tick();
        check("abort_residual", {31'd0, bus.cmd_valid}, 32'd0);
        check("abort_empty", {31'd0, bus.cmd_empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_host.md
LCD_HOST -- requirements
Module: lcd_host

Interface
REQ-001 Parameter: CMD_DEPTH, default 16, command FIFO depth (power of two).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 img_wr / img_addr / img_data  input  1/6/8  image preload write port.
REQ-005 cmd_push / cmd_in  input  1/4  command FIFO push strobe and code.
REQ-006 start  input  1  one-cycle pulse; begins command issue.
REQ-007 cmd_full / cmd_empty / cmd_ovf  output  1/1/1  FIFO full, FIFO empty, sticky overflow.
REQ-008 cmd / cmd_valid  output  4/1  command code and one-cycle valid toward the LCD controller.
REQ-009 busy / done  input  1/1  controller busy and done.
REQ-010 IROM_rd / IROM_A / IROM_Q  input/input/output  1/6/8  image ROM read port served by this block.
REQ-011 IRAM_valid / IRAM_A / IRAM_D  input  1/6/8  result write stream captured by this block.
REQ-012 ram_cnt / checksum / seq_err / finish  output  7/16/1/1  capture count, byte sum, sticky address-order error, completion.

Function
REQ-013 Image store SHALL be 64x8 registers; img_wr writes img_data at img_addr in any state except ISSUE.
REQ-014 When IROM_rd=1, IROM_Q SHALL update on the next edge to store[IROM_A] (one-cycle latency); otherwise IROM_Q holds its value.
REQ-015 Command FIFO: cmd_push with cmd_full=0 writes cmd_in; cmd_push with cmd_full=1 drops the entry and sets cmd_ovf until reset.
REQ-016 Push and pop in the same cycle on a full FIFO SHALL both succeed, with no overflow and count unchanged; on an empty FIFO no pop occurs.
REQ-017 Read/write pointers SHALL wrap modulo CMD_DEPTH; full = count==CMD_DEPTH, empty = count==0.
REQ-018 Issue FSM states: IDLE, WAIT_RDY, ISSUE, HOLD, COLLECT, FIN.
REQ-019 IDLE -> WAIT_RDY on start=1; start is ignored in all other states.
REQ-020 WAIT_RDY -> ISSUE when busy=0 and cmd_empty=0 in the same cycle; otherwise stay in WAIT_RDY.
REQ-021 ISSUE SHALL last exactly one cycle: cmd_valid=1, cmd=FIFO head, head popped.
REQ-022 ISSUE -> COLLECT if the issued code is 0 (write-out); otherwise ISSUE -> HOLD.
REQ-023 HOLD SHALL last exactly one cycle (cmd_valid=0), then go to WAIT_RDY; no two cmd_valid pulses are ever adjacent.
REQ-024 Outside ISSUE, cmd_valid=0 and cmd holds its last issued value.
REQ-025 In COLLECT, each cycle with IRAM_valid=1: ram_cnt+1 (saturating at 64), checksum += IRAM_D mod 2^16, expected address +1 (6-bit wrap).
REQ-026 seq_err SHALL set, sticky, on any IRAM_valid beat whose IRAM_A differs from the expected address (starts at 0).
REQ-027 IRAM_valid outside COLLECT SHALL be ignored, with no count, sum or error update.
REQ-028 COLLECT -> FIN when done=1; if IRAM_valid=1 in that same cycle, that beat is still captured.
REQ-029 In FIN, finish=1 and the FSM stays in FIN until reset; FIFO pushes remain legal but nothing is issued.
REQ-030 Commands remaining in the FIFO after a write-out issue SHALL NOT be issued.

Reset
REQ-031 On reset=1 at an edge, the block SHALL enter IDLE and clear the FIFO pointers, count and cmd_ovf; cmd_empty=1, cmd_full=0.
REQ-032 On the same edge, cmd=0, cmd_valid=0, IROM_Q=0, ram_cnt=0, checksum=0, seq_err=0, finish=0, expected address=0.
REQ-033 Image store contents SHALL be cleared to 0 on reset.
REQ-034 Reset asserted mid-ISSUE or mid-COLLECT SHALL abort at the next edge, with no residual cmd_valid pulse.

Verification
REQ-035 Preload store[k]=k; drive IROM_rd=1 with IROM_A=0..63 -> IROM_Q equals the previous cycle's address, 0..63.
REQ-036 Push 1,4,5,0, pulse start, busy=0 -> cmd_valid pulses carry 1,4,5,0, separated by at least one idle cycle; FSM ends in COLLECT.
REQ-037 Hold busy=1 for 10 cycles with the FIFO non-empty -> no cmd_valid; first pulse follows the first cycle with busy=0.
REQ-038 Push 17 entries with CMD_DEPTH=16 -> cmd_full=1, cmd_ovf=1, 16 entries retained.
REQ-039 In COLLECT, send 64 beats A=0..63, D=A, then done=1 -> ram_cnt=64, checksum=2016, seq_err=0, finish=1.
REQ-040 In COLLECT, send A sequence 0,1,3 -> seq_err=1 after the third beat; assert reset mid-stream -> all outputs return to reset values.
